// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period arithmetic.
// Used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Integer-truncated number of clk cycles per serial bit.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and line/status signals between a byte producer and uart_tx.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx;
    logic                  busy;
    logic                  done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx, busy, done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx, busy, done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: o_tick is high for one cycle every
// CLKS_PER_BIT cycles; i_restart holds the count at zero.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_period
        $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
    end

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_restart || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, one-entry holding register,
// LSB-first framing with one start bit and STOP_BITS stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_t           r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [BIT_W-1:0]      r_bit_idx, w_bit_idx_next;
    logic                  r_tx, w_tx_next;
    logic                  r_done, w_done_next;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid, w_hold_valid_next;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_tick;

    // Counter is parked at zero while idle so a new frame starts a full bit period.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (r_state == IDLE),
        .o_tick    (w_tick)
    );

    assign w_accept = bus.tx_valid && !r_hold_valid;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = r_tx;
        w_done_next    = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (r_hold_valid) begin
                    w_load       = 1'b1;
                    w_shift_next = r_hold;
                    w_tx_next    = 1'b0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                        w_tx_next      = 1'b1;
                        w_bit_idx_next = '0;
                        w_state_next   = STOP;
                    end else begin
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_bit_idx == BIT_W'(STOP_BITS - 1)) begin
                        w_done_next    = 1'b1;
                        w_bit_idx_next = '0;
                        // A waiting byte starts immediately so streamed frames abut.
                        if (r_hold_valid) begin
                            w_load       = 1'b1;
                            w_shift_next = r_hold;
                            w_tx_next    = 1'b0;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = IDLE;
            end
        endcase

        w_hold_valid_next = r_hold_valid;
        if (w_load) begin
            w_hold_valid_next = 1'b0;
        end else if (w_accept) begin
            w_hold_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_tx         <= w_tx_next;
            r_done       <= w_done_next;
            r_hold_valid <= w_hold_valid_next;
            if (w_accept) begin
                r_hold <= bus.tx_data;
            end
        end
    end

    assign bus.tx_ready = !r_hold_valid;
    assign bus.tx       = r_tx;
    assign bus.busy     = (r_state != IDLE) || r_hold_valid;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits, short bit periods),
// cycle-exact line model plus a behavioural serial receiver.
module tb_uart_tx;
    localparam int CPB1 = 1_000_000 / 115_200;   // truncates to 8
    localparam int CPB2 = 1_000_000 / 200_000;   // 5
    localparam int FL1  = (1 + 8 + 1) * CPB1;
    localparam int FL2  = (1 + 8 + 2) * CPB2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    int         sel       = 0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data  = 8'h00;
    int         vectors     = 0;
    int         miscompares = 0;

    uart_tx_if #(.DATA_WIDTH(8)) bus1 ();
    uart_tx_if #(.DATA_WIDTH(8)) bus2 ();

    assign bus1.tx_valid = drv_valid && (sel == 0);
    assign bus2.tx_valid = drv_valid && (sel == 1);
    assign bus1.tx_data  = drv_data;
    assign bus2.tx_data  = drv_data;

    uart_tx #(.BAUD_RATE(115_200), .DATA_WIDTH(8), .CLK_FREQ(1_000_000), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    uart_tx #(.BAUD_RATE(200_000), .DATA_WIDTH(8), .CLK_FREQ(1_000_000), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    wire m_tx    = (sel == 0) ? bus1.tx       : bus2.tx;
    wire m_ready = (sel == 0) ? bus1.tx_ready : bus2.tx_ready;
    wire m_busy  = (sel == 0) ? bus1.busy     : bus2.busy;
    wire m_done  = (sel == 0) ? bus1.done     : bus2.done;

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int cur_cpb();
        return (sel == 0) ? CPB1 : CPB2;
    endfunction

    function automatic int cur_fl();
        return (sel == 0) ? FL1 : FL2;
    endfunction

    // Line level t cycles after a frame's falling edge: start, 8 data LSB first, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int t);
        int k;
        k = t / cur_cpb();
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural receiver: mid-bit sampling, framing errors counted.
    int         rx_t    = -1;
    logic       prev_tx = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;

    always begin : monitor
        int c, ns, k;
        @(posedge clk);
        #1;
        c  = cur_cpb();
        ns = (sel == 0) ? 1 : 2;
        if (!rst_n) begin
            rx_t    = -1;
            prev_tx = 1'b1;
        end else begin
            if (rx_t < 0) begin
                if (prev_tx && !m_tx) rx_t = 0;
            end else begin
                rx_t++;
            end
            if (rx_t >= 0 && (rx_t % c) == c / 2) begin
                k = rx_t / c;
                if (k == 0) begin
                    if (m_tx !== 1'b0) rx_ferr++;
                end else if (k <= 8) begin
                    rx_byte[k-1] = m_tx;
                end else begin
                    if (m_tx !== 1'b1) rx_ferr++;
                    if (k == 8 + ns) begin
                        rx_q.push_back(rx_byte);
                        rx_t = -1;
                    end
                end
            end
            prev_tx = m_tx;
        end
    end

    task automatic test_reset();
        sel = 0;
        drv_data = 8'h00; drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (m_tx !== 1'b1)    begin miscompares++; $display("FAIL reset_tx: got %b want 1", m_tx); end
        vectors++; if (m_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", m_ready); end
        vectors++; if (m_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b want 0", m_busy); end
        vectors++; if (m_done !== 1'b0)  begin miscompares++; $display("FAIL reset_done: got %b want 0", m_done); end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if (m_tx !== 1'b1)    begin miscompares++; $display("FAIL post_reset_tx c%0d: got %b want 1", i, m_tx); end
            vectors++; if (m_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready c%0d: got %b want 1", i, m_ready); end
            vectors++; if (m_busy !== 1'b0)  begin miscompares++; $display("FAIL post_reset_busy c%0d: got %b want 0", i, m_busy); end
            vectors++; if (m_done !== 1'b0)  begin miscompares++; $display("FAIL post_reset_done c%0d: got %b want 0", i, m_done); end
        end
        $display("txn reset: mid-frame reset and 10 idle cycles checked");
    endtask

    task automatic test_single(input int s, input logic [7:0] b);
        int fl;
        sel = s; fl = cur_fl();
        drv_data = b; drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0; drv_data = ~b;
        vectors++; if (m_tx !== 1'b1 || m_ready !== 1'b0) begin
            miscompares++; $display("FAIL single_accept: tx %b ready %b want tx 1 ready 0", m_tx, m_ready);
        end
        tick();
        for (int t = 0; t <= fl; t++) begin
            vectors++; if (m_tx !== exp_bit(b, t)) begin
                miscompares++; $display("FAIL single_tx t=%0d: got %b want %b", t, m_tx, exp_bit(b, t));
            end
            vectors++; if (m_done !== (t == fl)) begin
                miscompares++; $display("FAIL single_done t=%0d: got %b want %b", t, m_done, (t == fl));
            end
            vectors++; if (m_busy !== (t < fl)) begin
                miscompares++; $display("FAIL single_busy t=%0d: got %b want %b", t, m_busy, (t < fl));
            end
            tick();
        end
        vectors++; if (m_done !== 1'b0) begin miscompares++; $display("FAIL single_done_width: got %b want 0", m_done); end
        $display("txn single: dut%0d byte %h", s + 1, b);
    endtask

    task automatic test_stream(input int s);
        int fl;
        logic       acc, want_tx, want_done, want_ready;
        logic [7:0] sent [3];
        logic [7:0] q[$];
        sel = s; fl = cur_fl();
        sent[0] = 8'h00; sent[1] = 8'hFF; sent[2] = 8'h55;
        q = {8'h00, 8'hFF, 8'h55};
        drv_valid = 1'b1; drv_data = q[0];
        tick();
        void'(q.pop_front());
        drv_data = q[0];
        tick();
        for (int t = 0; t <= 3 * fl + 1; t++) begin
            want_tx    = (t < 3 * fl) ? exp_bit(sent[t / fl], t % fl) : 1'b1;
            want_done  = (t > 0) && (t % fl == 0) && (t <= 3 * fl);
            want_ready = !((t > 0) && (t < 2 * fl) && (t % fl != 0));
            vectors++; if (m_tx !== want_tx) begin miscompares++; $display("FAIL stream_tx t=%0d: got %b want %b", t, m_tx, want_tx); end
            vectors++; if (m_done !== want_done) begin miscompares++; $display("FAIL stream_done t=%0d: got %b want %b", t, m_done, want_done); end
            vectors++; if (m_ready !== want_ready) begin miscompares++; $display("FAIL stream_ready t=%0d: got %b want %b", t, m_ready, want_ready); end
            vectors++; if (m_busy !== (t < 3 * fl)) begin miscompares++; $display("FAIL stream_busy t=%0d: got %b want %b", t, m_busy, (t < 3 * fl)); end
            acc = m_ready && drv_valid;
            tick();
            if (acc) begin
                void'(q.pop_front());
                if (q.size() > 0) drv_data = q[0];
                else drv_valid = 1'b0;
            end
        end
        drv_valid = 1'b0;
        $display("txn stream: dut%0d bytes 00 ff 55", s + 1);
    endtask

    task automatic test_backpressure();
        int n, fl, ferr0;
        logic [7:0] want [3];
        sel = 0; fl = FL1; rx_q.delete(); ferr0 = rx_ferr;
        want[0] = 8'h5A; want[1] = 8'hA0; want[2] = 8'h33;
        drv_valid = 1'b1; drv_data = 8'h5A;
        tick();
        drv_data = 8'hA0;
        tick();
        tick();
        n = 0;
        while (m_ready !== 1'b1 && n < 2 * fl) begin
            drv_data = (n % 2 == 0) ? 8'h11 : 8'h22;
            tick(); n++;
        end
        vectors++; if (n != fl - 1) begin miscompares++; $display("FAIL bp_ready_rise: after %0d cycles want %0d", n, fl - 1); end
        drv_data = 8'h33;
        tick();
        drv_valid = 1'b0; drv_data = 8'hEE;
        vectors++; if (m_ready !== 1'b0) begin miscompares++; $display("FAIL bp_capture: ready %b want 0", m_ready); end
        n = 0;
        while (rx_q.size() < 3 && n < 3 * fl) begin tick(); n++; end
        repeat (fl) tick();
        vectors++; if (rx_q.size() != 3) begin miscompares++; $display("FAIL bp_count: got %0d bytes want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            vectors++; if (rx_q[i] !== want[i]) begin miscompares++; $display("FAIL bp_byte%0d: got %h want %h", i, rx_q[i], want[i]); end
        end
        vectors++; if (rx_ferr != ferr0) begin miscompares++; $display("FAIL bp_framing: %0d errors want 0", rx_ferr - ferr0); end
        vectors++; if (m_busy !== 1'b0) begin miscompares++; $display("FAIL bp_busy: got %b want 0", m_busy); end
        $display("txn backpressure: 5a a0 33 with 11/22 offered while full");
    endtask

    task automatic test_reset_midframe();
        int fl, off;
        sel = 0; fl = FL1;
        drv_valid = 1'b1; drv_data = 8'hC3;
        tick();
        drv_data = 8'h99;
        tick();
        tick();
        drv_valid = 1'b0;
        off = 3 * CPB1 + CPB1 / 2;
        repeat (off - 1) tick();
        vectors++; if (m_tx !== exp_bit(8'hC3, off) || m_busy !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_pre: tx %b busy %b want tx %b busy 1", m_tx, m_busy, exp_bit(8'hC3, off));
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (m_tx !== 1'b1) begin miscompares++; $display("FAIL rst_mid_tx: got %b want 1", m_tx); end
        vectors++; if (m_busy !== 1'b0 || m_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_state: busy %b ready %b want 0 1", m_busy, m_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * fl; i++) begin
            tick();
            vectors++; if (m_tx !== 1'b1 || m_done !== 1'b0 || m_busy !== 1'b0) begin
                miscompares++; $display("FAIL rst_mid_quiet c%0d: tx %b done %b busy %b want 1 0 0", i, m_tx, m_done, m_busy);
            end
        end
        $display("txn reset_midframe: c3 in flight and 99 held discarded");
    endtask

    task automatic test_loopback(input int s, input int n);
        int fl, idx, cycles, ferr0;
        logic acc;
        logic [7:0] sent[$];
        sel = s; fl = cur_fl(); rx_q.delete(); ferr0 = rx_ferr;
        for (int i = 0; i < n; i++) sent.push_back(8'($urandom_range(0, 255)));
        idx = 0; cycles = 0;
        drv_valid = 1'b1; drv_data = sent[0];
        while (rx_q.size() < n && cycles < (n + 4) * fl) begin
            acc = m_ready && drv_valid;
            tick(); cycles++;
            if (acc) begin
                idx++;
                if (idx < n) drv_data = sent[idx];
                else drv_valid = 1'b0;
            end
        end
        drv_valid = 1'b0;
        vectors++; if (rx_q.size() != n) begin miscompares++; $display("FAIL loop_count dut%0d: got %0d bytes want %0d", s + 1, rx_q.size(), n); end
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            vectors++; if (rx_q[i] !== sent[i]) begin
                miscompares++; $display("FAIL loop_byte dut%0d #%0d: got %h want %h", s + 1, i, rx_q[i], sent[i]);
            end else begin
                $display("txn loopback: dut%0d #%0d byte %h", s + 1, i, sent[i]);
            end
        end
        vectors++; if (rx_ferr != ferr0) begin miscompares++; $display("FAIL loop_framing dut%0d: %0d errors want 0", s + 1, rx_ferr - ferr0); end
        repeat (2 * fl) tick();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single(0, 8'hA5);
        test_single(1, 8'hA5);
        test_stream(0);
        test_stream(1);
        test_backpressure();
        test_reset_midframe();
        test_single(0, 8'h7E);
        test_loopback(0, 64);
        test_loopback(1, 64);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
